motor_step_ctrl: RTL
====================

Name: motor_step_ctrl

Overview:
Downstream of the 5-key entry stage. Consumes the committed BCD target (hundreds/tens/ones) and the one-hot motor select, and drives STEP/DIR to move the selected stepper from its stored position to the target. Keeps one absolute position register per motor (6 motors, range 0..999). Moves one motor at a time and reports Busy/Done/Err to the display/status logic.

Parameters:
STEP_PERIOD, 50000, sysclk cycles per step (high + low); must be >= PULSE_W+1
PULSE_W, 100, sysclk cycles STEP is held high; >= 1
MAX_POS, 999, soft travel limit in steps (used only with SOFT_LIMIT_EN)

Ports:
rst  in  1  asynchronous, active-low reset
sysclk  in  1  system clock
INIT  in  1  synchronous clear, same effect as reset, highest priority after rst
Go  in  1  commit strobe (Enter level from the entry stage); rising edge starts a move
TValue0  in  4  target hundreds digit, BCD
TValue1  in  4  target tens digit, BCD
TValue2  in  4  target ones digit, BCD
Motor  in  6  one-hot motor select, bit0 = motor 1 .. bit5 = motor 6
Step  out  6  step pulse, one bit per motor
Dir  out  6  direction per motor, 1 = increasing position
Busy  out  1  high from CHECK through the final STEP_LO
Done  out  1  one-cycle pulse when a move (or null move) completes
Err  out  1  one-cycle pulse on a rejected command
CurPos  out  10  binary position of the most recently commanded motor

Behaviour:
- Reset (rst=0) or INIT=1: state IDLE; Step=0, Dir=0, Busy=0, Done=0, Err=0, CurPos=0; all six position registers = 0; Go edge detector cleared.
- Go edge detect: registered GoPrev; start = Go & ~GoPrev, evaluated only in IDLE. Go edges in any other state are ignored, not queued.
- States:
  - IDLE -> LOAD on start.
  - LOAD: captures Motor and target = TValue0*100 + TValue1*10 + TValue2 (10-bit binary). Capture occurs one edge after start, so it sees values the entry stage commits on the same edge as Enter. -> CHECK.
  - CHECK: if the captured Motor is not exactly one-hot, or any digit > 9: Err=1 for 1 cycle, positions unchanged -> IDLE. Otherwise CurPos = position of the selected motor. If target == position: Done=1 for 1 cycle -> IDLE, no Step activity. Else Dir[sel] = (target > position), Busy=1 -> STEP_HI. Dir is therefore valid >= 1 cycle before the first Step rise.
  - STEP_HI: Step[sel]=1 for exactly PULSE_W cycles. On the last cycle the position is incremented or decremented by 1 and CurPos follows. -> STEP_LO.
  - STEP_LO: Step=0 for STEP_PERIOD-PULSE_W cycles. Then -> DONE if position == target, else -> STEP_HI.
  - DONE: Done=1 for 1 cycle, Busy=0 -> IDLE.
- Step count = |target - start position|. Total move time = N*STEP_PERIOD cycles from the first Step rise to the Done pulse.
- Only Step[sel] ever pulses. Other Step bits stay 0; other Dir bits hold their last value.
- Dir[sel] holds after the move ends.
- Position arithmetic is 10-bit unsigned. Underflow below 0 is impossible because the target is >= 0.
- Phase counter width = $clog2(STEP_PERIOD); counter reloads on each state entry.
- INIT or reset mid-move: motion aborts immediately and positions clear to 0 (re-home semantics).

Optional Feature:
SOFT_LIMIT_EN
- Defined: in CHECK, a target > MAX_POS raises Err (1 cycle), no motion, -> IDLE.
- Undefined: MAX_POS is ignored; any BCD target 0..999 is accepted.

Test Plan:
Use STEP_PERIOD=4, PULSE_W=2 throughout.
- Reset, then Motor=000001, T=0/0/5, Go 0->1: Dir[0]=1 before the first Step. Exactly 5 Step[0] pulses, each high 2 cycles, period 4. Done pulse at 20 cycles after the first rise. CurPos=5.
- Same motor, T=0/0/2, Go: Dir[0]=0, 3 pulses, CurPos=2, Step[5:1] stay 0 throughout.
- Motor=000100, T=0/0/0 at position 0: Done pulse in CHECK, zero Step pulses, Busy never asserted.
- Motor=000011, T=1/2/3: single Err pulse, no Step, all positions unchanged. Repeat with Motor=000000: same result.
- Go re-asserted while Busy (Motor=100000, T=0/1/0 mid-move): ignored, move completes at 10. INIT asserted mid-move on a second command: Step drops within 1 cycle, Busy=0, CurPos=0.
- With SOFT_LIMIT_EN and MAX_POS=500, T=6/0/0: Err pulse, no motion. Without the macro: 600 pulses, CurPos=600.

Source files
------------

// File: rtl/motor_step_ctrl.sv
// motor_step_ctrl: moves one of six steppers from its stored absolute position to a BCD target,
// one motor at a time. Define SOFT_LIMIT_EN to reject targets above MAX_POS.
module motor_step_ctrl #(
    parameter int STEP_PERIOD = 50000,
    parameter int PULSE_W     = 100,
    parameter int MAX_POS     = 999
) (
    input  logic       rst,
    input  logic       sysclk,
    input  logic       INIT,
    input  logic       Go,
    input  logic [3:0] TValue0,
    input  logic [3:0] TValue1,
    input  logic [3:0] TValue2,
    input  logic [5:0] Motor,
    output logic [5:0] Step,
    output logic [5:0] Dir,
    output logic       Busy,
    output logic       Done,
    output logic       Err,
    output logic [9:0] CurPos
);
    localparam int CNT_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] LO_LOAD = CNT_W'(STEP_PERIOD - PULSE_W - 1);
`ifdef SOFT_LIMIT_EN
    localparam int LIMIT = MAX_POS;
`else
    // BCD targets never exceed 999, so this limit can never trip
    localparam int LIMIT = (MAX_POS > 999) ? MAX_POS : 999;
`endif

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_STEP_HI, S_STEP_LO, S_DONE} state_t;
    state_t r_state, w_next;

    logic             r_goPrev;
    logic [5:0]       r_sel;
    logic [9:0]       r_target;
    logic             r_digitBad;
    logic [9:0]       r_pos [6];
    logic [5:0]       r_dir;
    logic [9:0]       r_curPos;
    logic [CNT_W-1:0] r_cnt;

    logic       w_start, w_oneHot, w_limitBad, w_reject, w_up, w_cntZero, w_atTarget;
    logic [9:0] w_selPos, w_stepPos, w_bcdTarget;
    logic [5:0] w_newDir;

    assign w_start     = Go & ~r_goPrev;
    assign w_bcdTarget = ({6'd0, TValue0} * 10'd100) + ({6'd0, TValue1} * 10'd10) + {6'd0, TValue2};
    assign w_oneHot    = (r_sel != 6'd0) && ((r_sel & (r_sel - 6'd1)) == 6'd0);
    assign w_limitBad  = int'(r_target) > LIMIT;
    assign w_reject    = !w_oneHot || r_digitBad || w_limitBad;
    assign w_atTarget  = (w_selPos == r_target);
    assign w_up        = (r_target > w_selPos);
    assign w_stepPos   = w_up ? (w_selPos + 10'd1) : (w_selPos - 10'd1);
    assign w_newDir    = w_up ? (r_dir | r_sel) : (r_dir & ~r_sel);
    assign w_cntZero   = (r_cnt == '0);
    assign CurPos      = r_curPos;

    always_comb begin
        w_selPos = '0;
        for (int i = 0; i < 6; i++) begin
            if (r_sel[i]) w_selPos = r_pos[i];
        end
    end

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst)      r_state <= S_IDLE;
        else if (INIT) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    // Dir for the selected motor is shown combinationally in CHECK so it leads the first Step rise
    always_comb begin
        w_next = r_state;
        Step   = '0;
        Dir    = r_dir;
        Busy   = 1'b0;
        Done   = 1'b0;
        Err    = 1'b0;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_LOAD;
            S_LOAD:  w_next = S_CHECK;
            S_CHECK: begin
                if (w_reject) begin
                    Err    = 1'b1;
                    w_next = S_IDLE;
                end else if (w_atTarget) begin
                    Done   = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    Busy   = 1'b1;
                    Dir    = w_newDir;
                    w_next = S_STEP_HI;
                end
            end
            S_STEP_HI: begin
                Step = r_sel;
                Busy = 1'b1;
                if (w_cntZero) w_next = S_STEP_LO;
            end
            S_STEP_LO: begin
                Busy = 1'b1;
                if (w_cntZero) w_next = w_atTarget ? S_DONE : S_STEP_HI;
            end
            S_DONE: begin
                Done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst || INIT) begin
            r_goPrev   <= 1'b0;
            r_sel      <= '0;
            r_target   <= '0;
            r_digitBad <= 1'b0;
            r_dir      <= '0;
            r_curPos   <= '0;
            r_cnt      <= '0;
            for (int i = 0; i < 6; i++) r_pos[i] <= '0;
        end else begin
            r_goPrev <= Go;
            case (r_state)
                S_LOAD: begin
                    r_sel      <= Motor;
                    r_target   <= w_bcdTarget;
                    r_digitBad <= (TValue0 > 4'd9) || (TValue1 > 4'd9) || (TValue2 > 4'd9);
                end
                S_CHECK: begin
                    if (!w_reject) r_curPos <= w_selPos;
                    if (!w_reject && !w_atTarget) begin
                        r_dir <= w_newDir;
                        r_cnt <= HI_LOAD;
                    end
                end
                S_STEP_HI: begin
                    if (w_cntZero) begin
                        for (int i = 0; i < 6; i++) begin
                            if (r_sel[i]) r_pos[i] <= w_stepPos;
                        end
                        r_curPos <= w_stepPos;
                        r_cnt    <= LO_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_STEP_LO: begin
                    if (w_cntZero) r_cnt <= HI_LOAD;
                    else           r_cnt <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
